// File: rtl/ysyx_201979054_imm_decode_stage_pkg.sv
// Shared types for the immediate-decode stage: immediate select codes, RV64 opcodes
// and the two-entry skid-buffer state.
package ysyx_201979054_imm_decode_stage_pkg;

  typedef enum logic [2:0] {
    ImmI   = 3'b000,
    ImmS   = 3'b001,
    ImmB   = 3'b010,
    ImmJ   = 3'b011,
    ImmU   = 3'b100,
    ImmCsr = 3'b101
  } imm_src_t;

  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpOpImm   = 7'b0010011;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpOpImm32 = 7'b0011011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpOp      = 7'b0110011;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpOp32    = 7'b0111011;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpSystem  = 7'b1110011;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StTwo   = 2'b10
  } buf_state_e;

endpackage

// File: rtl/ysyx_201979054_extend_imm.sv
// Immediate extender: builds the XLEN-bit immediate from instr[31:7] for a given type.
module ysyx_201979054_extend_imm
  import ysyx_201979054_imm_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [24:0]     instr_hi,
  input  imm_src_t        imm_src,
  output logic [XLEN-1:0] imm
);

  // instr_hi[k] is instr[k+7]
  logic sign;
  assign sign = instr_hi[24];

  always_comb begin
    imm = '0;
    case (imm_src)
      ImmI:   imm = {{(XLEN-12){sign}}, instr_hi[24:13]};
      ImmS:   imm = {{(XLEN-12){sign}}, instr_hi[24:18], instr_hi[4:0]};
      ImmB:   imm = {{(XLEN-12){sign}}, instr_hi[0], instr_hi[23:18], instr_hi[4:1], 1'b0};
      ImmJ:   imm = {{(XLEN-20){sign}}, instr_hi[12:5], instr_hi[13], instr_hi[23:14], 1'b0};
      ImmU:   imm = {{(XLEN-32){sign}}, instr_hi[24:5], 12'b0};
      ImmCsr: imm = {{(XLEN-5){1'b0}}, instr_hi[12:8]};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_201979054_imm_decode_stage.sv
// Immediate-decode pipeline stage with a two-entry skid buffer and registered ready.
// IMM_DEC_ILLEGAL_CHECK_EN enables illegal-opcode flagging (imm and has_imm forced to 0).
module ysyx_201979054_imm_decode_stage
  import ysyx_201979054_imm_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned ILEN = 32
) (
  input  logic            clk,
  input  logic            arstn,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [ILEN-1:0] i_instr,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [ILEN-1:0] o_instr,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_imm_src,
  output logic            o_has_imm,
  output logic            o_illegal
);

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] imm;
    imm_src_t        imm_src;
    logic            has_imm;
    logic            illegal;
  } entry_t;

  imm_src_t        dec_src;
  logic            dec_has_imm;
  logic            dec_illegal;
  logic [XLEN-1:0] ext_imm;
  entry_t          dec_entry;

  always_comb begin
    dec_src     = ImmI;
    dec_has_imm = 1'b1;
    dec_illegal = 1'b0;
    case (i_instr[6:0])
      OpLoad, OpOpImm, OpOpImm32, OpJalr, OpMiscMem: dec_src = ImmI;
      OpStore:         dec_src = ImmS;
      OpBranch:        dec_src = ImmB;
      OpJal:           dec_src = ImmJ;
      OpLui, OpAuipc:  dec_src = ImmU;
      OpOp, OpOp32:    dec_has_imm = 1'b0;
      OpSystem: begin
        if (i_instr[14]) dec_src = ImmCsr;
`ifdef IMM_DEC_ILLEGAL_CHECK_EN
        if (i_instr[14:12] == 3'b100) begin
          dec_illegal = 1'b1;
          dec_has_imm = 1'b0;
        end
`endif
      end
      default: begin
`ifdef IMM_DEC_ILLEGAL_CHECK_EN
        dec_illegal = 1'b1;
        dec_has_imm = 1'b0;
`else
        dec_src = ImmI;
`endif
      end
    endcase
  end

  ysyx_201979054_extend_imm #(
    .XLEN (XLEN)
  ) u_extend_imm (
    .instr_hi (i_instr[31:7]),
    .imm_src  (dec_src),
    .imm      (ext_imm)
  );

  always_comb begin
    dec_entry.instr   = i_instr;
    dec_entry.imm     = dec_illegal ? '0 : ext_imm;
    dec_entry.imm_src = dec_src;
    dec_entry.has_imm = dec_has_imm;
    dec_entry.illegal = dec_illegal;
  end

  buf_state_e state_q, state_d;
  entry_t     main_q, skid_q;
  logic       accept, pop;
  logic       main_load_in, main_load_skid, skid_load;

  assign accept = i_valid & o_ready;
  assign pop    = o_valid & i_ready;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state_q <= StEmpty;
    else        state_q <= state_d;
  end

  // Flush wins over any accept or pop in the same cycle; no entry is written.
  always_comb begin
    state_d        = state_q;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (i_flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d      = StOne;
            main_load_in = 1'b1;
          end
        end
        StOne: begin
          if (accept && !pop) begin
            state_d   = StTwo;
            skid_load = 1'b1;
          end else if (pop && !accept) begin
            state_d = StEmpty;
          end else if (accept && pop) begin
            main_load_in = 1'b1;
          end
        end
        StTwo: begin
          if (pop) begin
            state_d        = StOne;
            main_load_skid = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    o_valid = (state_q != StEmpty);
    o_ready = (state_q != StTwo);
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_load_in)        main_q <= dec_entry;
      else if (main_load_skid) main_q <= skid_q;
      if (skid_load)           skid_q <= dec_entry;
    end
  end

  assign o_instr   = main_q.instr;
  assign o_imm     = main_q.imm;
  assign o_imm_src = main_q.imm_src;
  assign o_has_imm = main_q.has_imm;
  assign o_illegal = main_q.illegal;

endmodule

// File: tb/tb_ysyx_201979054_imm_decode_stage.sv
// Directed bench for the immediate-decode stage: decode vectors, skid buffering,
// flush and asynchronous reset.
module tb_ysyx_201979054_imm_decode_stage;

  logic        clk;
  logic        arstn;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instr;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [63:0] o_imm;
  logic [2:0]  o_imm_src;
  logic        o_has_imm;
  logic        o_illegal;

  int n_vec = 0;
  int n_err = 0;

  ysyx_201979054_imm_decode_stage #(
    .XLEN (64),
    .ILEN (32)
  ) dut (
    .clk       (clk),
    .arstn     (arstn),
    .i_flush   (i_flush),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_instr   (i_instr),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_instr   (o_instr),
    .o_imm     (o_imm),
    .o_imm_src (o_imm_src),
    .o_has_imm (o_has_imm),
    .o_illegal (o_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [63:0] imm;
    logic        has_imm;
    logic        illegal;
    logic        chk_src;
    logic        chk_imm;
    string       name;
  } vec_t;

  localparam logic [31:0] Addi  = 32'hFFF0_0093;
  localparam logic [31:0] Lui   = 32'h8000_00B7;
  localparam logic [31:0] Beq   = 32'hFE00_0EE3;

  task automatic test_reset();
    arstn = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_instr = '0;
    repeat (2) @(negedge clk);
    n_vec++; if (o_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_vec++; if (o_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_ready: got %b want 1", o_ready); end
    n_vec++; if (o_imm !== 64'h0) begin n_err++;
      $display("FAIL reset_imm: got %h want 0", o_imm); end
    n_vec++; if (o_instr !== 32'h0 || o_imm_src !== 3'b0 || o_has_imm !== 1'b0
                 || o_illegal !== 1'b0) begin n_err++;
      $display("FAIL reset_data: instr %h src %b has %b ill %b want all 0",
               o_instr, o_imm_src, o_has_imm, o_illegal); end
    arstn = 1'b1;
  endtask

  task automatic test_decode();
    vec_t v[8];
    v[0] = '{Addi,         3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, "addi"};
    v[1] = '{Lui,          3'b100, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0, 1'b1, 1'b1, "lui"};
    v[2] = '{Beq,          3'b010, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b1, "beq"};
    v[3] = '{32'h3002_D073, 3'b101, 64'h5,                  1'b1, 1'b0, 1'b1, 1'b1, "csrrwi"};
    v[4] = '{32'h0080_00EF, 3'b011, 64'h8,                  1'b1, 1'b0, 1'b1, 1'b1, "jal"};
    v[5] = '{32'hFE20_AE23, 3'b001, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b1, "sw"};
    v[6] = '{32'h0020_81B3, 3'b000, 64'h0,                  1'b0, 1'b0, 1'b1, 1'b0, "add"};
`ifdef IMM_DEC_ILLEGAL_CHECK_EN
    v[7] = '{32'h0000_007F, 3'b000, 64'h0,                  1'b0, 1'b1, 1'b0, 1'b1, "bad_op"};
`else
    v[7] = '{32'h0000_007F, 3'b000, 64'h0,                  1'b1, 1'b0, 1'b1, 1'b1, "bad_op"};
`endif
    i_ready = 1'b1;
    // One word per cycle: each negedge checks the previous word and drives the next.
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_vec++; if (o_valid !== 1'b1) begin n_err++;
          $display("FAIL %s_valid: got %b want 1", v[i-1].name, o_valid); end
        n_vec++; if (o_instr !== v[i-1].instr) begin n_err++;
          $display("FAIL %s_instr: got %h want %h", v[i-1].name, o_instr, v[i-1].instr); end
        if (v[i-1].chk_src) begin
          n_vec++; if (o_imm_src !== v[i-1].src) begin n_err++;
            $display("FAIL %s_src: got %b want %b", v[i-1].name, o_imm_src, v[i-1].src); end
        end
        if (v[i-1].chk_imm) begin
          n_vec++; if (o_imm !== v[i-1].imm) begin n_err++;
            $display("FAIL %s_imm: got %h want %h", v[i-1].name, o_imm, v[i-1].imm); end
        end
        n_vec++; if (o_has_imm !== v[i-1].has_imm || o_illegal !== v[i-1].illegal) begin
          n_err++;
          $display("FAIL %s_flags: has %b ill %b want has %b ill %b", v[i-1].name,
                   o_has_imm, o_illegal, v[i-1].has_imm, v[i-1].illegal);
        end
      end
      if (i < 8) begin i_valid = 1'b1; i_instr = v[i].instr; end
      else i_valid = 1'b0;
    end
    @(negedge clk);
    n_vec++; if (o_valid !== 1'b0) begin n_err++;
      $display("FAIL drain_valid: got %b want 0", o_valid); end
  endtask

  task automatic test_skid();
    i_ready = 1'b0;
    @(negedge clk); i_valid = 1'b1; i_instr = Addi;
    @(negedge clk);
    n_vec++; if (o_valid !== 1'b1 || o_ready !== 1'b1 || o_instr !== Addi) begin n_err++;
      $display("FAIL skid_one: valid %b ready %b instr %h want 1 1 %h",
               o_valid, o_ready, o_instr, Addi); end
    i_instr = Lui;
    @(negedge clk);
    n_vec++; if (o_ready !== 1'b0 || o_instr !== Addi) begin n_err++;
      $display("FAIL skid_two: ready %b instr %h want 0 %h", o_ready, o_instr, Addi); end
    i_instr = Beq;
    @(negedge clk);
    n_vec++; if (o_ready !== 1'b0 || o_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++;
      $display("FAIL skid_hold: ready %b imm %h want 0 ffffffffffffffff", o_ready, o_imm); end
    i_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (o_instr !== Lui || o_imm !== 64'hFFFF_FFFF_8000_0000 || o_ready !== 1'b1)
    begin n_err++;
      $display("FAIL skid_pop1: instr %h imm %h ready %b want %h ffffffff80000000 1",
               o_instr, o_imm, o_ready, Lui); end
    @(negedge clk);
    i_valid = 1'b0;
    n_vec++; if (o_valid !== 1'b1 || o_instr !== Beq || o_imm_src !== 3'b010) begin n_err++;
      $display("FAIL skid_pop2: valid %b instr %h src %b want 1 %h 010",
               o_valid, o_instr, o_imm_src, Beq); end
    @(negedge clk);
    n_vec++; if (o_valid !== 1'b0) begin n_err++;
      $display("FAIL skid_empty: valid %b want 0", o_valid); end
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    @(negedge clk); i_valid = 1'b1; i_instr = Addi;
    @(negedge clk); i_instr = Lui;
    @(negedge clk);
    n_vec++; if (o_ready !== 1'b0) begin n_err++;
      $display("FAIL flush_pre: ready %b want 0", o_ready); end
    i_flush = 1'b1; i_instr = Beq;
    @(negedge clk);
    n_vec++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_err++;
      $display("FAIL flush_state: valid %b ready %b want 0 1", o_valid, o_ready); end
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (o_valid !== 1'b0) begin n_err++;
      $display("FAIL flush_drop: valid %b want 0", o_valid); end
  endtask

  task automatic test_async_reset();
    i_ready = 1'b0;
    @(negedge clk); i_valid = 1'b1; i_instr = Lui;
    @(negedge clk); i_valid = 1'b0;
    n_vec++; if (o_valid !== 1'b1) begin n_err++;
      $display("FAIL areset_pre: valid %b want 1", o_valid); end
    @(posedge clk); #2;
    arstn = 1'b0;
    #1;
    n_vec++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_imm !== 64'h0 || o_instr !== 32'h0)
    begin n_err++;
      $display("FAIL areset_clear: valid %b ready %b imm %h instr %h want 0 1 0 0",
               o_valid, o_ready, o_imm, o_instr); end
    @(negedge clk); arstn = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (o_valid !== 1'b0) begin n_err++;
      $display("FAIL areset_replay: valid %b want 0", o_valid); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_skid();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_201979054_imm_decode_stage.md
# ysyx_201979054_imm_decode_stage

Pipelined immediate-decode stage sitting between instruction fetch and execute. It accepts 32-bit RV64 instructions over a valid/ready handshake and classifies each opcode into an immediate type. It drives the shared immediate extender and registers the 64-bit result, the select code and the instruction in a two-entry skid buffer. The upstream ready signal is therefore fully registered.

## Interface
- `XLEN`, 64, width of extended immediate.
- `ILEN`, 32, instruction width.
- `clk`  in  1  system clock, rising edge.
- `arstn`  in  1  asynchronous active-low reset.
- `i_flush`  in  1  synchronous pipeline flush.
- `i_valid`  in  1  upstream instruction valid.
- `o_ready`  out  1  stage can accept; registered.
- `i_instr`  in  ILEN  instruction word.
- `o_valid`  out  1  downstream data valid.
- `i_ready`  in  1  downstream accepts.
- `o_instr`  out  ILEN  registered instruction.
- `o_imm`  out  XLEN  extended immediate.
- `o_imm_src`  out  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U, 101 CSR.
- `o_has_imm`  out  1  0 for R-type (OP, OP-32).
- `o_illegal`  out  1  unrecognised opcode.

## Operation
- Extender input is `instr[31:7]` (25 bits). `imm_src` is decoded from `instr[6:0]`:
  - I type (000): LOAD 0000011, OP-IMM 0010011, OP-IMM-32 0011011, JALR 1100111, MISC-MEM 0001111.
  - S type (001): STORE 0100011.
  - B type (010): BRANCH 1100011.
  - J type (011): JAL 1101111.
  - U type (100): LUI 0110111, AUIPC 0010111.
  - SYSTEM 1110011: CSR (101) if `funct3[2]`=1, otherwise I type (000).
  - OP 0110011 and OP-32 0111011: select 000, `o_has_imm`=0.
  - Anything else is illegal.
- Width rules:
  - I, S, B and J are sign-extended from `instr[31]`.
  - U is `{32{instr[31]}, instr[31:12], 12'b0}`.
  - CSR is zero-extended `instr[19:15]`.
- State machine, with accept = `i_valid & o_ready` and pop = `o_valid & i_ready`:
  - EMPTY: accept → ONE.
  - ONE: accept without pop → TWO (word goes to skid); pop without accept → EMPTY; accept and pop together → ONE (main reloaded).
  - TWO: pop → ONE (skid moves to main); no accept is possible.
- `o_valid` = state≠EMPTY. `o_ready` = state≠TWO. Outputs always present the main entry, so FIFO order is preserved.
- `i_flush` → EMPTY on the next edge. Flush has priority over a simultaneous accept or pop, and the flushed word is dropped.
- Reset values: state EMPTY, `o_valid` 0, `o_ready` 1, all data outputs 0.

## Timing
- Latency: a word accepted at edge N is on the outputs with `o_valid`=1 after edge N.
- Throughput: one instruction per cycle while `i_ready`=1.
- Outputs hold stable while `o_valid & !i_ready`.
- `o_ready` drops the cycle after the second unpopped accept, and rises the cycle after the pop from TWO.
- Reset asserted mid-transfer clears both entries immediately; nothing is replayed.

## Configuration
- `IMM_DEC_ILLEGAL_CHECK_EN` defined:
  - Illegal opcodes set `o_illegal`=1, `o_imm`=0, `o_has_imm`=0.
  - SYSTEM with `funct3`=100 is also illegal.
- Undefined:
  - `o_illegal` tied 0.
  - Unknown opcodes decode as I type with a normal extended immediate.

## Structure
- Shared package holds:
  - the `imm_src_t` enum (the six 3-bit codes);
  - opcode localparams;
  - the buffer-state enum (EMPTY, ONE, TWO).
- One sub-module: `ysyx_201979054_extend_imm`, instantiated combinationally on the incoming instruction. Results are registered into the main or skid entry.

## Test plan
- addi x1,x0,-1 (0xFFF00093), `i_ready`=1 → next cycle `o_imm_src`=000, `o_imm`=0xFFFFFFFFFFFFFFFF, `o_has_imm`=1.
- lui x1,0x80000 (0x800000B7) → `o_imm_src`=100, `o_imm`=0xFFFFFFFF80000000. beq x0,x0,-4 (0xFE000EE3) → 010, 0xFFFFFFFFFFFFFFFC.
- csrrwi x0,mstatus,5 (0x3002D073) → `o_imm_src`=101, `o_imm`=0x5.
- `i_ready`=0, stream 3 valid words → `o_ready` is 0 after 2 accepts. Raise `i_ready` → words come out in order, one per cycle, third accepted after the first pop.
- In state TWO, assert `i_flush` together with `i_valid` → next cycle `o_valid`=0, `o_ready`=1, no word emitted.
- Opcode 0x7F (word 0x0000007F) with macro defined → `o_illegal`=1, `o_imm`=0. Without macro → `o_illegal`=0, `o_imm_src`=000.
